// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory port, decoder port,
// execute-stage redirect and the architectural PC.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        halt;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    input  halt,
    input  br_taken,
    input  br_target,
    output pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    output halt,
    output br_taken,
    output br_target,
    input  pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word fetch, one-word
// buffer to the decoder, branch redirect and permanent halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master f
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    FLUSH,
    HALTED
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc_q;
  logic [31:0] pc_n;
  logic [31:0] addr_q;
  logic [31:0] addr_n;
  logic [31:0] instr_q;
  logic [31:0] instr_n;
  logic [31:0] ipc_q;
  logic [31:0] ipc_n;
  logic        valid_q;
  logic        valid_n;
  logic [31:0] tgt;
  logic        take;

  assign tgt  = f.br_target & ~32'h3;
  assign take = valid_q & f.instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
      valid_q <= valid_n;
    end
  end

  // addr_q is the request address; it only moves when a new
  // request starts, so it stays put through FLUSH.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    addr_n  = addr_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    valid_n = valid_q;
    unique case (state)
      IDLE: begin
        state_n = FETCH;
        addr_n  = pc_q;
      end
      FETCH: begin
        if (f.br_taken) begin
          pc_n    = tgt;
          valid_n = 1'b0;
          if (f.imem_ack) begin
            state_n = FETCH;
            addr_n  = tgt;
          end else begin
            state_n = FLUSH;
          end
        end else if (f.imem_ack) begin
          instr_n = f.imem_rdata;
          ipc_n   = pc_q;
          pc_n    = pc_q + 32'd4;
          valid_n = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (take && f.halt) begin
          valid_n = 1'b0;
          state_n = HALTED;
        end else if (f.br_taken) begin
          pc_n    = tgt;
          addr_n  = tgt;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (take) begin
          valid_n = 1'b0;
          addr_n  = pc_q;
          state_n = FETCH;
        end
      end
      FLUSH: begin
        if (f.br_taken) begin
          pc_n = tgt;
        end
        if (f.imem_ack) begin
          addr_n  = f.br_taken ? tgt : pc_q;
          state_n = FETCH;
        end
      end
      HALTED: begin
        valid_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign f.imem_req    = (state == FETCH) || (state == FLUSH);
  assign f.imem_addr   = addr_q;
  assign f.instr_valid = valid_q;
  assign f.instr       = instr_q;
  assign f.instr_pc    = ipc_q;
  assign f.pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios then random traffic against a
// transaction-level model of the fetch stream.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk),
    .rst(rst),
    .f  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rd,
                       input logic rdy, input logic hl,
                       input logic br, input logic [31:0] tg);
    bus.imem_ack    = ack;
    bus.imem_rdata  = rd;
    bus.instr_ready = rdy;
    bus.halt        = hl;
    bus.br_taken    = br;
    bus.br_target   = tg;
  endtask

  logic [31:0] exp_word;
  logic [31:0] held;
  logic [31:0] o_addr;
  logic        o_valid;
  logic        o_req;
  logic        halted;
  int          hcnt;
  logic        d_ack;
  logic        d_rdy;
  logic        d_halt;
  logic        d_br;
  logic [31:0] d_rd;
  logic [31:0] d_tgt;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_req", {31'b0, bus.imem_req}, 0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_ipc", bus.instr_pc, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_pc", bus.pc, 32'h100);

    // 1: first fetch
    rst = 1'b0;
    chk("t1_idle_req", {31'b0, bus.imem_req}, 0);
    tick();
    chk("t1_req", {31'b0, bus.imem_req}, 1);
    chk("t1_addr", bus.imem_addr, 32'h100);
    drive(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_valid", {31'b0, bus.instr_valid}, 1);
    chk("t1_instr", bus.instr, 32'hDEAD_BEEF);
    chk("t1_ipc", bus.instr_pc, 32'h100);
    chk("t1_pc", bus.pc, 32'h104);

    // 2: backpressure
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h5555_5555, 0, 0, 0, 0);
      tick();
      chk("t2_instr", bus.instr, 32'hDEAD_BEEF);
      chk("t2_req", {31'b0, bus.imem_req}, 0);
      chk("t2_valid", {31'b0, bus.instr_valid}, 1);
    end
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_req_after", {31'b0, bus.imem_req}, 1);
    chk("t2_addr", bus.imem_addr, 32'h104);
    chk("t2_valid_after", {31'b0, bus.instr_valid}, 0);

    // 3: redirect in HOLD beats ready
    drive(1, 32'h1111_1111, 0, 0, 0, 0);
    tick();
    chk("t3_valid", {31'b0, bus.instr_valid}, 1);
    drive(0, 0, 1, 0, 1, 32'h2003);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t3_valid_off", {31'b0, bus.instr_valid}, 0);
    chk("t3_req", {31'b0, bus.imem_req}, 1);
    chk("t3_addr", bus.imem_addr, 32'h2000);
    chk("t3_pc", bus.pc, 32'h2000);

    // 4: redirect with request outstanding
    drive(0, 0, 0, 0, 1, 32'h400);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_pc", bus.pc, 32'h400);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_req", {31'b0, bus.imem_req}, 1);
      chk("t4_hold_addr", bus.imem_addr, 32'h2000);
      if (i < 2) tick();
    end
    drive(1, 32'hBAD0_BAD0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_no_valid", {31'b0, bus.instr_valid}, 0);
    chk("t4_req", {31'b0, bus.imem_req}, 1);
    chk("t4_addr", bus.imem_addr, 32'h400);
    drive(1, 32'h0C0F_FEE0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_instr", bus.instr, 32'h0C0F_FEE0);
    chk("t4_ipc", bus.instr_pc, 32'h400);

    // 5: halt beats redirect, then sticks until reset
    drive(0, 0, 1, 1, 1, 32'h800);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("t5_req", {31'b0, bus.imem_req}, 0);
      chk("t5_valid", {31'b0, bus.instr_valid}, 0);
      chk("t5_pc", bus.pc, 32'h404);
      drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom),
            1'($urandom), $urandom);
      tick();
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_restart_req", {31'b0, bus.imem_req}, 1);
    chk("t5_restart_addr", bus.imem_addr, 32'h100);

    // 6: wrap and async reset
    drive(1, 32'hAAAA_AAAA, 0, 0, 1, 32'hFFFF_FFFE);
    tick();
    chk("t6_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("t6_valid0", {31'b0, bus.instr_valid}, 0);
    drive(1, 32'h1234_5678, 0, 0, 0, 0);
    tick();
    chk("t6_instr", bus.instr, 32'h1234_5678);
    chk("t6_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    chk("t6_pc_wrap", bus.pc, 32'h0);
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_addr0", bus.imem_addr, 32'h0);
    chk("t6_req", {31'b0, bus.imem_req}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_req", {31'b0, bus.imem_req}, 0);
    chk("t6_async_valid", {31'b0, bus.instr_valid}, 0);
    chk("t6_async_pc", bus.pc, 32'h100);
    tick();
    rst = 1'b0;
    tick();

    // random traffic
    exp_word = 32'h100;
    halted   = 1'b0;
    hcnt     = 0;
    for (int n = 0; n < 3000; n++) begin
      o_valid = bus.instr_valid;
      o_req   = bus.imem_req;
      o_addr  = bus.imem_addr;
      d_ack   = o_req ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      d_rd    = (o_req && d_ack) ? mem(o_addr) : $urandom;
      d_rdy   = 1'($urandom_range(1));
      d_halt  = ($urandom_range(40) == 0);
      d_br    = ($urandom_range(9) == 0);
      d_tgt   = ($urandom_range(3) == 0) ?
                (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      drive(d_ack, d_rd, d_rdy, d_halt, d_br, d_tgt);
      tick();
      if (!halted) begin
        if (o_valid && d_rdy && d_halt) halted = 1'b1;
        else if (d_br) exp_word = d_tgt & ~32'h3;
      end
      if (halted) begin
        chk("r_halt_req", {31'b0, bus.imem_req}, 0);
        chk("r_halt_valid", {31'b0, bus.instr_valid}, 0);
        chk("r_halt_pc", bus.pc, exp_word);
        hcnt++;
      end else begin
        if (bus.instr_valid && !o_valid) begin
          held = bus.instr_pc;
          chk("r_word_pc", held, exp_word);
          chk("r_word_data", bus.instr, mem(held));
          exp_word = exp_word + 32'd4;
        end
        chk("r_pc", bus.pc, exp_word);
        if (o_req && !d_ack && bus.imem_req)
          chk("r_addr_stable", bus.imem_addr, o_addr);
      end
      if (hcnt > 6) begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        chk("r_rst_pc", bus.pc, 32'h100);
        tick();
        exp_word = 32'h100;
        halted   = 1'b0;
        hcnt     = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
